visor_trace: RTL and testbench

- Execution-trace capture buffer that sits directly downstream of the visor.
- Consumes the target code address and fetched opcode on every target execute cycle, plus the visor breakpoint-hit flag.
- Records them into a circular history RAM that the supervisor MCU reads back after a halt, giving "how did we get here" history.
- Outputs are plain registers; the visor maps them onto its reg_ifc source/dest registers.

---
 rtl/visor_trace_if.sv | 42 ++++
 rtl/visor_trace.sv | 162 ++++++++++++++++
 tb/tb_visor_trace.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/visor_trace_if.sv
// Trace-buffer signal bundle between the visor (master) and visor_trace (slave).
// VISOR_TRACE_DEDUP_EN adds the rd_repeat readback field.
interface visor_trace_if #(
  parameter int DEPTH = 64
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [15:0]    tg_addr;
  logic [15:0]    tg_opcode;
  logic           tg_exec;
  logic           bp_hit;
  logic           arm;
  logic           stop;
  logic [IDX_W-1:0] rd_idx;
  logic [15:0]    rd_addr;
  logic [15:0]    rd_opcode;
  logic           rd_valid;
  logic [IDX_W:0] count;
  logic           wrapped;
  logic [1:0]     state;
`ifdef VISOR_TRACE_DEDUP_EN
  logic [15:0]    rd_repeat;

  modport master (
    output tg_addr, tg_opcode, tg_exec, bp_hit, arm, stop, rd_idx,
    input  rd_addr, rd_opcode, rd_valid, count, wrapped, state, rd_repeat
  );
  modport slave (
    input  tg_addr, tg_opcode, tg_exec, bp_hit, arm, stop, rd_idx,
    output rd_addr, rd_opcode, rd_valid, count, wrapped, state, rd_repeat
  );
`else
  modport master (
    output tg_addr, tg_opcode, tg_exec, bp_hit, arm, stop, rd_idx,
    input  rd_addr, rd_opcode, rd_valid, count, wrapped, state
  );
  modport slave (
    input  tg_addr, tg_opcode, tg_exec, bp_hit, arm, stop, rd_idx,
    output rd_addr, rd_opcode, rd_valid, count, wrapped, state
  );
`endif
endinterface

// File: rtl/visor_trace.sv
// Circular execution-trace history buffer; newest entry is read back at rd_idx = 0.
// Optional macro VISOR_TRACE_DEDUP_EN folds repeated addresses into a repeat counter.
module visor_trace #(
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  visor_trace_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] wr_ptr_reg;
  logic [IDX_W:0]   count_reg;
  logic             wrapped_reg;
  logic             bp_q_reg;

  logic [31:0]      mem [DEPTH];

  logic             bp_rise;
  logic             capture;
  logic             dup;
  logic             new_entry;
  logic [IDX_W-1:0] rd_slot;
  logic             rd_hit;

  logic             rd_valid_reg;
  logic [15:0]      rd_addr_reg;
  logic [15:0]      rd_opcode_reg;

  assign bp_rise   = bus.bp_hit & ~bp_q_reg;
  // arm and stop both suppress a same-cycle capture
  assign capture   = (state_reg == RUN) & bus.tg_exec & ~bus.arm & ~bus.stop;
  assign new_entry = capture & ~dup;

  assign rd_slot = wr_ptr_reg - IDX_W'(1) - bus.rd_idx;
  assign rd_hit  = ({1'b0, bus.rd_idx} < count_reg);

`ifdef VISOR_TRACE_DEDUP_EN
  logic [15:0] newest_addr_reg;
  logic [15:0] newest_rep_reg;
  logic [15:0] rep_next;
  logic [15:0] rep_mem [DEPTH];
  logic [15:0] rd_repeat_reg;

  assign dup      = (count_reg != '0) && (bus.tg_addr == newest_addr_reg);
  assign rep_next = (newest_rep_reg == 16'hFFFF) ? 16'hFFFF : newest_rep_reg + 16'd1;

  // Shadow of the newest entry so a repeat needs no RAM read-modify-write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      newest_addr_reg <= '0;
      newest_rep_reg  <= '0;
    end else if (capture) begin
      if (dup) begin
        newest_rep_reg <= rep_next;
      end else begin
        newest_addr_reg <= bus.tg_addr;
        newest_rep_reg  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (new_entry) begin
      rep_mem[wr_ptr_reg] <= '0;
    end else if (capture) begin
      rep_mem[wr_ptr_reg - IDX_W'(1)] <= rep_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_repeat_reg <= '0;
    end else begin
      rd_repeat_reg <= rd_hit ? rep_mem[rd_slot] : 16'h0000;
    end
  end

  assign bus.rd_repeat = rd_repeat_reg;
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
      bp_q_reg    <= 1'b0;
    end else begin
      bp_q_reg <= bus.bp_hit;
      if (bus.arm) begin
        state_reg   <= RUN;
        wr_ptr_reg  <= '0;
        count_reg   <= '0;
        wrapped_reg <= 1'b0;
      end else begin
        if (new_entry) begin
          wr_ptr_reg <= wr_ptr_reg + IDX_W'(1);
          if (count_reg != DEPTH_CNT) begin
            count_reg <= count_reg + 1'b1;
          end
          if (wr_ptr_reg == '1) begin
            wrapped_reg <= 1'b1;
          end
        end
        // A capture coinciding with the bp edge is kept, so the breakpoint is newest
        case (state_reg)
          RUN: begin
            if (bus.stop) begin
              state_reg <= IDLE;
            end else if (bp_rise) begin
              state_reg <= FROZEN;
            end
          end
          FROZEN: begin
            if (bus.stop) begin
              state_reg <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (new_entry) begin
      mem[wr_ptr_reg] <= {bus.tg_addr, bus.tg_opcode};
    end
  end

  // Read sees the pre-write pointer and RAM contents of this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_reg  <= 1'b0;
      rd_addr_reg   <= '0;
      rd_opcode_reg <= '0;
    end else begin
      rd_valid_reg  <= rd_hit;
      rd_addr_reg   <= rd_hit ? mem[rd_slot][31:16] : 16'h0000;
      rd_opcode_reg <= rd_hit ? mem[rd_slot][15:0]  : 16'h0000;
    end
  end

  assign bus.rd_valid  = rd_valid_reg;
  assign bus.rd_addr   = rd_addr_reg;
  assign bus.rd_opcode = rd_opcode_reg;
  assign bus.count     = count_reg;
  assign bus.wrapped   = wrapped_reg;
  assign bus.state     = state_reg;

endmodule

// File: tb/tb_visor_trace.sv
// Randomized + directed bench for visor_trace against a queue-based history model.
module tb_visor_trace;
  localparam int DEPTH = 64;
  localparam int IDX_W = $clog2(DEPTH);

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  visor_trace_if #(.DEPTH(DEPTH)) bus ();

  visor_trace #(.DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] o;
    logic [15:0] r;
  } ent_t;

  ent_t hist[$];   // newest at index 0
  int   m_tot;     // new entries since arm
  int   m_st;      // 0 idle, 1 run, 2 frozen
  logic m_bp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_tot = 0;
    m_st  = 0;
    m_bp  = 1'b0;
  endtask

  task automatic model_capture();
    ent_t e;
`ifdef VISOR_TRACE_DEDUP_EN
    if (hist.size() > 0 && hist[0].a == bus.tg_addr) begin
      e = hist[0];
      if (e.r != 16'hFFFF) e.r = e.r + 16'd1;
      hist[0] = e;
      return;
    end
`endif
    e.a = bus.tg_addr;
    e.o = bus.tg_opcode;
    e.r = 16'h0000;
    hist.push_front(e);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    m_tot++;
  endtask

  // One clock: predict readback from the pre-edge history, advance the model, compare.
  task automatic cycle();
    logic        ev;
    logic [15:0] ea, eo, er;
    int          idx;
    logic        bp_rise;
    idx = int'(bus.rd_idx);
    if (idx < hist.size()) begin
      ev = 1'b1; ea = hist[idx].a; eo = hist[idx].o; er = hist[idx].r;
    end else begin
      ev = 1'b0; ea = '0; eo = '0; er = '0;
    end
    bp_rise = bus.bp_hit && !m_bp;
    if (bus.arm) begin
      m_st = 1;
      hist.delete();
      m_tot = 0;
    end else if (m_st == 1) begin
      if (bus.stop) m_st = 0;
      else begin
        if (bus.tg_exec) model_capture();
        if (bp_rise) m_st = 2;
      end
    end else if (m_st == 2 && bus.stop) begin
      m_st = 0;
    end
    m_bp = bus.bp_hit;
    @(posedge clk);
    #1;
    check("rd_valid",  32'(bus.rd_valid),  32'(ev));
    check("rd_addr",   32'(bus.rd_addr),   32'(ea));
    check("rd_opcode", 32'(bus.rd_opcode), 32'(eo));
`ifdef VISOR_TRACE_DEDUP_EN
    check("rd_repeat", 32'(bus.rd_repeat), 32'(er));
`endif
    check("count",     32'(bus.count),     32'(hist.size()));
    check("wrapped",   32'(bus.wrapped),   32'(m_tot >= DEPTH));
    check("state",     32'(bus.state),     32'(m_st));
  endtask

  task automatic step(input logic e, input logic [15:0] a, input logic b,
                      input logic ar, input logic sp, input int ri);
    bus.tg_exec   = e;
    bus.tg_addr   = a;
    bus.tg_opcode = 16'($urandom);
    bus.bp_hit    = b;
    bus.arm       = ar;
    bus.stop      = sp;
    bus.rd_idx    = IDX_W'(ri);
    cycle();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
    check({tag, "_rd_addr"},   32'(bus.rd_addr),   32'd0);
    check({tag, "_rd_opcode"}, 32'(bus.rd_opcode), 32'd0);
    check({tag, "_count"},     32'(bus.count),     32'd0);
    check({tag, "_wrapped"},   32'(bus.wrapped),   32'd0);
    check({tag, "_state"},     32'(bus.state),     32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.tg_exec = 1'b0; bus.tg_addr = '0; bus.tg_opcode = '0;
    bus.bp_hit = 1'b0; bus.arm = 1'b0; bus.stop = 1'b0; bus.rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    $display("txn reset released");

    // Five captures, readback of newest, oldest and out of range
    step(0, 16'h0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h10 + 16'(i), 0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0, 0);
    check("t1_newest", 32'(bus.rd_addr), 32'h14);
    check("t1_newest_v", 32'(bus.rd_valid), 32'd1);
    step(0, 16'h0, 0, 0, 0, 4);
    check("t1_oldest", 32'(bus.rd_addr), 32'h10);
    step(0, 16'h0, 0, 0, 0, 5);
    check("t1_oor_v", 32'(bus.rd_valid), 32'd0);
    check("t1_count", 32'(bus.count), 32'd5);
    $display("txn five captures done");

    // Wrap: 70 captures into 64 slots
    step(0, 16'h0, 0, 1, 0, 0);
    for (int i = 0; i < 70; i++) step(1, 16'(i), 0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0, 0);
    check("t2_newest", 32'(bus.rd_addr), 32'd69);
    check("t2_wrapped", 32'(bus.wrapped), 32'd1);
    step(0, 16'h0, 0, 0, 0, 63);
    check("t2_oldest", 32'(bus.rd_addr), 32'd6);
    check("t2_count", 32'(bus.count), 32'd64);
    $display("txn wrap done");

    // Breakpoint edge with capture, then arm while bp held
    step(1, 16'h2A, 1, 0, 0, 0);
    check("t3_frozen", 32'(bus.state), 32'd2);
    step(0, 16'h0, 1, 0, 0, 0);
    check("t3_bp_entry", 32'(bus.rd_addr), 32'h2A);
    for (int i = 0; i < 3; i++) step(1, 16'h50 + 16'(i), 1, 0, 0, 0);
    step(0, 16'h0, 1, 1, 0, 0);
    check("t3_rearm_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 16'h60 + 16'(i), 1, 0, 0, 0);
    check("t3_still_run", 32'(bus.state), 32'd1);
    $display("txn breakpoint freeze done");

    // Asynchronous reset mid-capture
    step(0, 16'h0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 16'h100 + 16'(i), 0, 0, 0, 0);
    bus.tg_exec = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 16'h200 + 16'(i), 0, 0, 0, 0);
    check("t4_ignored", 32'(bus.count), 32'd0);
    $display("txn async reset done");

    // stop beats capture; arm beats stop
    step(0, 16'h0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h300 + 16'(i), 0, 0, 0, 0);
    step(1, 16'h3FF, 0, 0, 1, 0);
    check("t5_count", 32'(bus.count), 32'd3);
    check("t5_idle", 32'(bus.state), 32'd0);
    step(0, 16'h0, 0, 1, 1, 0);
    check("t5_run", 32'(bus.state), 32'd1);
    $display("txn stop/arm priority done");

`ifdef VISOR_TRACE_DEDUP_EN
    step(0, 16'h0, 0, 1, 0, 0);
    step(1, 16'h30, 0, 0, 0, 0);
    step(1, 16'h30, 0, 0, 0, 0);
    step(1, 16'h30, 0, 0, 0, 0);
    step(1, 16'h31, 0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0, 1);
    check("t6_count", 32'(bus.count), 32'd2);
    check("t6_old_addr", 32'(bus.rd_addr), 32'h30);
    check("t6_old_rep", 32'(bus.rd_repeat), 32'd2);
    step(0, 16'h0, 0, 0, 0, 0);
    check("t6_new_addr", 32'(bus.rd_addr), 32'h31);
    check("t6_new_rep", 32'(bus.rd_repeat), 32'd0);
    $display("txn dedup done");
`endif

    // Random traffic against the model
    begin
      logic b;
      b = 1'b0;
      for (int n = 0; n < 2000; n++) begin
        logic e, ar, sp;
        logic [15:0] a;
        int ri;
        if ($urandom_range(0, 49) == 0) b = ~b;
        e  = ($urandom_range(0, 99) < 70);
        ar = ($urandom_range(0, 99) < 1) || (n == 0);
        sp = ($urandom_range(0, 99) < 1);
        a  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
        ri = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH-1));
        step(e, a, b, ar, sp, ri);
        $display("txn %0d exec=%0b addr=%h arm=%0b stop=%0b bp=%0b idx=%0d count=%0d",
                 n, e, a, ar, sp, b, ri, bus.count);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
